// File: rtl/bcd_conv_arbiter.sv
// Two-requester front end sharing one iterative double-dabble binary-to-BCD engine.
// Define BCD_ARB_RR_EN for round-robin tie breaking; default build uses fixed priority (requester 0).
module bcd_conv_arbiter #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  output logic                  bcd_valid,
  output logic                  bcd_id,
  output logic [4*DIGITS-1:0]   bcd_code,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   bin_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                id_q;
  logic                last_id_q;
  logic                bcd_valid_q;
  logic                bcd_id_q;
  logic [BCD_W-1:0]    bcd_code_q;

  logic                grant_d;
  logic                accept_d;
  logic [BCD_W-1:0]    bcd_adj_d;
  logic [BCD_W+DATA_W-1:0] shift_d;

`ifdef BCD_ARB_RR_EN
  always_comb begin
    grant_d = 1'b0;
    if (req0_valid && req1_valid) grant_d = ~last_id_q;
    else if (req1_valid)          grant_d = 1'b1;
  end
`else
  always_comb begin
    grant_d = ~req0_valid & req1_valid;
  end
`endif

  // Readys are forced low while reset is asserted, not just after the first edge.
  assign req0_ready = sys_rst_n & (state_q == IDLE) & ~grant_d;
  assign req1_ready = sys_rst_n & (state_q == IDLE) &  grant_d;
  assign accept_d   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Add-3 correction is per digit with no carry; a digit >= 5 can never exceed 12 here.
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    shift_d = {bcd_adj_d, bin_q} << 1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      bcd_valid_q <= 1'b0;
      bcd_id_q    <= 1'b0;
      bcd_code_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            bin_q   <= grant_d ? req1_data : req0_data;
            bcd_q   <= '0;
            id_q    <= grant_d;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= shift_d[BCD_W+DATA_W-1:DATA_W];
          bin_q <= shift_d[DATA_W-1:0];
          cnt_q <= cnt_q + 1'b1;
          // Result registers load on the final shift so they are valid alongside the DONE strobe.
          if (cnt_q == LAST_CNT) begin
            bcd_code_q  <= shift_d[BCD_W+DATA_W-1:DATA_W];
            bcd_id_q    <= id_q;
            bcd_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          bcd_valid_q <= 1'b0;
          last_id_q   <= id_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_valid = bcd_valid_q;
  assign bcd_id    = bcd_id_q;
  assign bcd_code  = bcd_code_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter with a decimal-reference scoreboard.
// Honours BCD_ARB_RR_EN for the contention expectations.
module tb_bcd_conv_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_data = '0;
  logic        req1_ready;
  logic        bcd_valid;
  logic        bcd_id;
  logic [19:0] bcd_code;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAccCyc = 0;
  int prevAccCyc = 0;
  int req1Accepts = 0;

  typedef struct {
    bit          id;
    logic [15:0] data;
    int          accCyc;
  } pend_t;
  pend_t pend[$];
  bit prevValid = 1'b0;
  bit sawAccept = 1'b0;

  bcd_conv_arbiter dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .bcd_valid  (bcd_valid),
    .bcd_id     (bcd_id),
    .bcd_code   (bcd_code),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [19:0] toBcd(input int value);
    int v;
    logic [19:0] r;
    v = value;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic digitsValid(input logic [19:0] code);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < 5; d++) if (code[4*d +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Scoreboard: records acceptances, checks every strobe against the decimal reference.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      pend.delete();
      prevValid = 1'b0;
      sawAccept = 1'b0;
    end else begin
      if (sawAccept) checkOutput("busy_after_accept", 32'(busy), 32'd1);
      sawAccept = 1'b0;
      if (busy) checkOutput("ready_while_busy", 32'({req0_ready, req1_ready}), 32'd0);
      if (bcd_valid) begin
        checkOutput("strobe_width", 32'(prevValid), 32'd0);
        if (pend.size() == 0) begin
          checkOutput("unexpected_strobe", 32'(bcd_valid), 32'd0);
        end else begin
          pend_t e;
          e = pend.pop_front();
          checkOutput("sb_code", 32'(bcd_code), 32'(toBcd(int'(e.data))));
          checkOutput("sb_id", 32'(bcd_id), 32'(e.id));
          checkOutput("sb_latency", 32'(cyc - e.accCyc), 32'd17);
          checkOutput("digit_range", 32'(digitsValid(bcd_code)), 32'd1);
        end
      end
      if (req0_valid && req0_ready) begin
        pend.push_back('{1'b0, req0_data, cyc});
        sawAccept = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        pend.push_back('{1'b1, req1_data, cyc});
        sawAccept = 1'b1;
        req1Accepts++;
      end
      if (sawAccept) begin
        prevAccCyc = lastAccCyc;
        lastAccCyc = cyc;
      end
      prevValid = bcd_valid;
    end
  end

  task automatic doReset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic waitAccept(input bit id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("accept_timeout", 32'(ok), 32'd1);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic waitStrobe();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (bcd_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("strobe_timeout", 32'(got), 32'd1);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input bit id, input logic [15:0] data, input logic [19:0] expCode);
    if (id) begin
      req1_valid = 1'b1;
      req1_data  = data;
    end else begin
      req0_valid = 1'b1;
      req0_data  = data;
    end
    waitAccept(id);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitStrobe();
    checkOutput("held_code", 32'(bcd_code), 32'(expCode));
    checkOutput("held_id", 32'(bcd_id), 32'(id));
  endtask

  logic [15:0] sweepVal;
  int          req1Before;

  initial begin
    // Reset values
    sys_rst_n = 1'b0;
    #2;
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("rst_bcd_valid", 32'(bcd_valid), 32'd0);
    checkOutput("rst_bcd_id", 32'(bcd_id), 32'd0);
    checkOutput("rst_bcd_code", 32'(bcd_code), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    doReset();
    @(posedge sys_clk);
    #1;

    // Single requests at the boundaries
    applyStimulus(1'b0, 16'd0,     20'h00000);
    applyStimulus(1'b0, 16'd65535, 20'h65535);
    applyStimulus(1'b0, 16'd9999,  20'h09999);
    applyStimulus(1'b1, 16'd10,    20'h00010);

    // Back-to-back on requester 0 with valid held high
    req0_valid = 1'b1;
    req0_data  = 16'd1234;
    waitAccept(1'b0);
    req0_data  = 16'd4321;
    waitStrobe();
    checkOutput("b2b_first", 32'(bcd_code), 32'h01234);
    waitAccept(1'b0);
    checkOutput("b2b_gap", 32'(lastAccCyc - prevAccCyc), 32'd18);
    req0_valid = 1'b0;
    waitStrobe();
    checkOutput("b2b_second", 32'(bcd_code), 32'h04321);

    // Contention from reset
    doReset();
    req1Before = req1Accepts;
    req0_data  = 16'd100;
    req1_data  = 16'd200;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitStrobe();
`ifdef BCD_ARB_RR_EN
      checkOutput("rr_id", 32'(bcd_id), 32'(k % 2));
      checkOutput("rr_code", 32'(bcd_code), (k % 2 == 1) ? 32'h00200 : 32'h00100);
`else
      checkOutput("fixed_id", 32'(bcd_id), 32'd0);
      checkOutput("fixed_code", 32'(bcd_code), 32'h00100);
`endif
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`ifdef BCD_ARB_RR_EN
    checkOutput("rr_req1_grants", 32'(req1Accepts - req1Before), 32'd2);
`else
    checkOutput("fixed_req1_starved", 32'(req1Accepts - req1Before), 32'd0);
`endif

    // Reset in the middle of a conversion
    req0_valid = 1'b1;
    req0_data  = 16'd5000;
    waitAccept(1'b0);
    req0_valid = 1'b0;
    repeat (7) @(posedge sys_clk);
    #2;
    checkOutput("pre_abort_busy", 32'(busy), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'({req0_ready, req1_ready}), 32'd0);
    checkOutput("abort_valid", 32'(bcd_valid), 32'd0);
    checkOutput("abort_id", 32'(bcd_id), 32'd0);
    checkOutput("abort_code", 32'(bcd_code), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (25) @(posedge sys_clk);
    #1;
    checkOutput("abort_no_result", 32'(bcd_code), 32'd0);
    applyStimulus(1'b0, 16'd42, 20'h00042);

    // Sparse sweep on alternating requesters, checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      sweepVal = 16'((i * 2749 + i * i * 7) % 65536);
      applyStimulus(i[0], sweepVal, toBcd(int'(sweepVal)));
    end

    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("sb_drained", 32'(pend.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
